// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared constants and types for the seven-segment scan path and the FSM's
// pattern encoder.
package sevenseg_pkg;

  localparam int SEG_W      = 7;
  localparam int AN_W       = 4;
  localparam int DIG_W      = 2;
  localparam int NUM_DIGITS = 4;

  localparam logic [SEG_W-1:0] SEG_ALL_OFF = 7'h7F;
  localparam logic [AN_W-1:0]  AN_ALL_OFF  = 4'hF;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_e;

  typedef enum logic {
    SCAN_IDLE,
    SCAN_RUN
  } scan_state_e;

  function automatic logic [AN_W-1:0] an_select(input logic [DIG_W-1:0] dig);
    an_select      = AN_ALL_OFF;
    an_select[dig] = 1'b0;
  endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Pattern bus between the regfile demo FSM (master) and the scan driver (slave).
interface sevenseg_scan_driver_if;
  import sevenseg_pkg::*;

  logic             enable;
  logic [SEG_W-1:0] seg0;
  logic [SEG_W-1:0] seg1;
  logic [SEG_W-1:0] seg2;
  logic [SEG_W-1:0] seg3;
  logic             frame_tick;

  modport master (output enable, seg0, seg1, seg2, seg3, input frame_tick);
  modport slave  (input enable, seg0, seg1, seg2, seg3, output frame_tick);

endinterface

// File: rtl/sevenseg_scan_driver_slot_timer.sv
// Slot/digit sequencer. Outputs describe the state taken at the coming edge so
// the top-level output flops line up with cnt/dig without extra latency.
module sevenseg_slot_timer
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             in_show,
  output logic [DIG_W-1:0] dig,
  output logic             frame_start
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  scan_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [DIG_W-1:0] dig_q, dig_nx;
  logic             past_blank;

  // IDLE marks "frame not yet started": the first enabled edge parks on
  // cnt=0/dig=0 and latches instead of advancing.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    dig_nx      = dig_q;
    frame_start = 1'b0;
    if (!enable) begin
      state_nx = SCAN_IDLE;
      cnt_nx   = '0;
      dig_nx   = '0;
    end else if (state == SCAN_IDLE) begin
      state_nx    = SCAN_RUN;
      frame_start = 1'b1;
    end else if (cnt == CNT_LAST) begin
      cnt_nx      = '0;
      dig_nx      = dig_q + 1'b1;
      frame_start = (dig_q == DIG_W'(NUM_DIGITS - 1));
    end else begin
      cnt_nx = cnt + 1'b1;
    end
  end

  if (BLANK_CYCLES == 0) begin : g_noblank
    assign past_blank = 1'b1;
  end else begin : g_blank
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    assign past_blank = (cnt_nx >= BLANK_END);
  end

  assign in_show = (state_nx == SCAN_RUN) && past_blank;
  assign dig     = dig_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCAN_IDLE;
      cnt   <= '0;
      dig_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dig_q <= dig_nx;
    end
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-frame shadow latching
// and a blanking gap ahead of every digit.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV       = 50000,
  parameter int BLANK_CYCLES      = 500,
  parameter int SEG_ACTIVE_LOW_IN = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  sevenseg_scan_driver_if.slave  pat,
  output logic [SEG_W-1:0]       seg_n,
  output logic [AN_W-1:0]        an_n
);

  localparam logic [SEG_W-1:0] SHADOW_OFF =
    (SEG_ACTIVE_LOW_IN != 0) ? SEG_ALL_OFF : ~SEG_ALL_OFF;

  logic             in_show;
  logic             frame_start;
  logic [DIG_W-1:0] dig;
  logic [SEG_W-1:0] shadow [NUM_DIGITS];
  logic [SEG_W-1:0] pattern;
  logic [SEG_W-1:0] seg_drive;

  sevenseg_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_slot_timer (
    .clk        (clk),
    .reset      (reset),
    .enable     (pat.enable),
    .in_show    (in_show),
    .dig        (dig),
    .frame_start(frame_start)
  );

  // A latch edge always lands on digit 0, so bypass the shadow with seg0 there
  // (only visible when there is no blanking gap).
  always_comb begin
    pattern   = frame_start ? pat.seg0 : shadow[dig];
    seg_drive = (SEG_ACTIVE_LOW_IN != 0) ? pattern : ~pattern;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) shadow[i] <= SHADOW_OFF;
      seg_n          <= SEG_ALL_OFF;
      an_n           <= AN_ALL_OFF;
      pat.frame_tick <= 1'b0;
    end else begin
      if (frame_start) begin
        shadow[0] <= pat.seg0;
        shadow[1] <= pat.seg1;
        shadow[2] <= pat.seg2;
        shadow[3] <= pat.seg3;
      end
      pat.frame_tick <= frame_start;
      if (in_show) begin
        an_n  <= an_select(dig);
        seg_n <= seg_drive;
      end else begin
        an_n  <= AN_ALL_OFF;
        seg_n <= SEG_ALL_OFF;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: three parameterisations share one stimulus and
// are compared every cycle against a frame-position reference model.
module tb_sevenseg_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] s0, s1, s2, s3;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  sevenseg_scan_driver_if pif0 ();
  sevenseg_scan_driver_if pif1 ();
  sevenseg_scan_driver_if pif2 ();

  assign pif0.enable = en; assign pif0.seg0 = s0; assign pif0.seg1 = s1;
  assign pif0.seg2 = s2;   assign pif0.seg3 = s3;
  assign pif1.enable = en; assign pif1.seg0 = s0; assign pif1.seg1 = s1;
  assign pif1.seg2 = s2;   assign pif1.seg3 = s3;
  assign pif2.enable = en; assign pif2.seg0 = s0; assign pif2.seg1 = s1;
  assign pif2.seg2 = s2;   assign pif2.seg3 = s3;

  logic [6:0] g0, g1, g2;
  logic [3:0] a0, a1, a2;

  sevenseg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW_IN(1)) dut0 (
    .clk(clk), .reset(rst), .pat(pif0), .seg_n(g0), .an_n(a0));
  sevenseg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW_IN(0)) dut1 (
    .clk(clk), .reset(rst), .pat(pif1), .seg_n(g1), .an_n(a1));
  sevenseg_scan_driver #(.REFRESH_DIV(3), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW_IN(1)) dut2 (
    .clk(clk), .reset(rst), .pat(pif2), .seg_n(g2), .an_n(a2));

  // Observed vector per instance: {an_n, seg_n, frame_tick}
  logic [11:0] obs [3];
  assign obs[0] = {a0, g0, pif0.frame_tick};
  assign obs[1] = {a1, g1, pif1.frame_tick};
  assign obs[2] = {a2, g2, pif2.frame_tick};

  function automatic int div_of(int k);   return (k == 2) ? 3 : 8; endfunction
  function automatic int blank_of(int k); return (k == 2) ? 0 : 2; endfunction
  function automatic bit alow_of(int k);  return (k != 1);         endfunction

  // Reference model: position within a 4*DIV-cycle frame, plus a frame-active flag.
  int          pos [3];
  bit          act [3];
  logic [6:0]  shd [3][4];
  logic [11:0] exp_v [3];
  int          m_d;
  bit          m_tk;
  logic [6:0]  m_seg;

  initial for (int k = 0; k < 3; k++) begin pos[k] = 0; act[k] = 0; end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      m_tk = 1'b0;
      if (rst) begin
        act[k] = 0; pos[k] = 0;
        for (int j = 0; j < 4; j++) shd[k][j] = alow_of(k) ? 7'h7F : 7'h00;
      end else if (!en) begin
        act[k] = 0; pos[k] = 0;
      end else begin
        if (!act[k]) begin
          act[k] = 1; pos[k] = 0;
        end else begin
          pos[k] = (pos[k] + 1) % (4 * div_of(k));
        end
        if (pos[k] == 0) begin
          m_tk = 1'b1;
          shd[k][0] = s0; shd[k][1] = s1; shd[k][2] = s2; shd[k][3] = s3;
        end
      end
      m_d = pos[k] / div_of(k);
      if (act[k] && (pos[k] % div_of(k)) >= blank_of(k)) begin
        m_seg    = alow_of(k) ? shd[k][m_d] : ~shd[k][m_d];
        exp_v[k] = {~(4'b0001 << m_d), m_seg, m_tk};
      end else begin
        exp_v[k] = {4'hF, 7'h7F, m_tk};
      end
    end
  end

  task automatic plan_values();
    s0 = 7'h40; s1 = 7'h79; s2 = 7'h24; s3 = 7'h30; en = 1'b1;
  endtask

  task automatic test_reset();
    plan_values();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== 12'hFFE) begin
          errors++;
          $display("FAIL reset dut%0d cyc%0d: got %b want %b", k, c, obs[k], 12'hFFE);
        end
        checks++;
        if (obs[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL reset_model dut%0d cyc%0d: got %b want %b", k, c, obs[k], exp_v[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [11:0] want;
    bit          chk;
    for (int c = 0; c < 56; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_v[k] || $countones(~obs[k][11:8]) > 1) begin
          errors++;
          $display("FAIL scan dut%0d cyc%0d: got %b want %b", k, c, obs[k], exp_v[k]);
        end
      end
      chk = 1'b1;
      case (c)
        0, 32:  want = {4'hF, 7'h7F, 1'b1};
        1:      want = {4'hF, 7'h7F, 1'b0};
        2, 7:   want = {4'b1110, 7'h40, 1'b0};
        8:      want = {4'hF, 7'h7F, 1'b0};
        10:     want = {4'b1101, 7'h79, 1'b0};
        18, 22: want = {4'b1011, 7'h24, 1'b0};
        26, 31: want = {4'b0111, 7'h30, 1'b0};
        50, 55: want = {4'b1011, 7'h00, 1'b0};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if (obs[0] !== want) begin
          errors++;
          $display("FAIL scan_plan cyc%0d: got %b want %b", c, obs[0], want);
        end
      end
      if (c == 19) s2 = 7'h00;
    end
  endtask

  task automatic test_enable_gap();
    logic [11:0] want;
    bit          chk;
    plan_values();
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_v[k] || $countones(~obs[k][11:8]) > 1) begin
          errors++;
          $display("FAIL enable dut%0d cyc%0d: got %b want %b", k, c, obs[k], exp_v[k]);
        end
      end
      chk = 1'b1;
      case (c)
        11:     want = {4'b1101, 7'h79, 1'b0};
        12, 16: want = {4'hF, 7'h7F, 1'b0};
        17:     want = {4'hF, 7'h7F, 1'b1};
        19:     want = {4'b1110, 7'h40, 1'b0};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if (obs[0] !== want) begin
          errors++;
          $display("FAIL enable_plan cyc%0d: got %b want %b", c, obs[0], want);
        end
      end
      if (c == 11) en = 1'b0;
      if (c == 16) en = 1'b1;
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] want;
    bit          chk;
    plan_values();
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 62; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_v[k] || $countones(~obs[k][11:8]) > 1) begin
          errors++;
          $display("FAIL rstmid dut%0d cyc%0d: got %b want %b", k, c, obs[k], exp_v[k]);
        end
      end
      chk = 1'b1;
      case (c)
        26:     want = {4'b0111, 7'h30, 1'b0};
        27:     want = {4'hF, 7'h7F, 1'b0};
        28, 60: want = {4'hF, 7'h7F, 1'b1};
        30:     want = {4'b1110, 7'h40, 1'b0};
        38:     want = {4'b1101, 7'h79, 1'b0};
        54:     want = {4'b0111, 7'h30, 1'b0};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if (obs[0] !== want) begin
          errors++;
          $display("FAIL rstmid_plan cyc%0d: got %b want %b", c, obs[0], want);
        end
      end
      rst = (c == 26);
    end
  endtask

  task automatic test_active_high();
    plan_values();
    s0 = 7'h3F;
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (obs[2] !== {4'b1110, 7'h3F, 1'b1}) begin
          errors++;
          $display("FAIL noblank_latch: got %b want %b", obs[2], {4'b1110, 7'h3F, 1'b1});
        end
      end
      if (c == 2) begin
        checks++;
        if (obs[1] !== {4'b1110, 7'h40, 1'b0}) begin
          errors++;
          $display("FAIL active_high: got %b want %b", obs[1], {4'b1110, 7'h40, 1'b0});
        end
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL acthi dut%0d cyc%0d: got %b want %b", k, c, obs[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_v[k] || $countones(~obs[k][11:8]) > 1) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: got %b want %b", k, c, obs[k], exp_v[k]);
        end
      end
      if ($urandom_range(0, 3) == 0) s0 = 7'($urandom);
      if ($urandom_range(0, 3) == 0) s1 = 7'($urandom);
      if ($urandom_range(0, 3) == 0) s2 = 7'($urandom);
      if ($urandom_range(0, 3) == 0) s3 = 7'($urandom);
      en  = ($urandom_range(0, 24) != 0);
      rst = ($urandom_range(0, 149) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_enable_gap();
    test_reset_midframe();
    test_active_high();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Consumes the four 7-bit digit patterns produced by the regfile demo FSM (`out0`..`out3`).
- Time-multiplexes them onto the board's shared seven-segment bus (active-low segments, active-low anodes).
- Shadow-latches all four patterns once per frame, so a display frame never mixes old and new values.
- Inserts a blanking gap before each digit to suppress ghosting; sits between the FSM and the top-level pins.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (50 MHz gives 1 kHz per digit, 250 Hz per frame); must be >= 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; 0 <= BLANK_CYCLES < REFRESH_DIV.
- SEG_ACTIVE_LOW_IN, 1: 1 means the input patterns are already active-low; 0 means the inputs are active-high and are inverted on output.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = scan; 0 = display dark, scan held at frame start.
- seg0  input  7  digit 0 pattern (rightmost digit), bit 0 = segment a ... bit 6 = segment g.
- seg1  input  7  digit 1 pattern.
- seg2  input  7  digit 2 pattern.
- seg3  input  7  digit 3 pattern (leftmost digit).
- seg_n  output  7  shared segment bus, active-low.
- an_n  output  4  anode selects, active-low; an_n[i]=0 selects digit i.
- frame_tick  output  1  one-cycle pulse in the cycle the shadow latch loads.

Behaviour:
- Single clock domain; reset is synchronous and active-high on clk. Reset overrides enable.
- Reset values: an_n=4'b1111, seg_n=7'h7F, frame_tick=0, slot counter cnt=0, digit index dig=0, all shadow registers = "all segments off".
- cnt counts 0..REFRESH_DIV-1; its width is $clog2(REFRESH_DIV). dig is 2 bits.
- When cnt==REFRESH_DIV-1: next cnt=0 and dig=dig+1, wrapping 3 to 0.
- State is decoded from cnt: BLANK when cnt<BLANK_CYCLES, SHOW otherwise. With BLANK_CYCLES=0 there is no BLANK state.
- Outputs in BLANK: an_n=4'b1111, seg_n=7'h7F.
- Outputs in SHOW: an_n = one-cold at dig. seg_n = shadow[dig] if SEG_ACTIVE_LOW_IN=1, else ~shadow[dig].
- All outputs are flip-flops. They are updated on the same edge as cnt and dig, so they always match the current registered state, with no extra latency.
- Latch event: in the cycle where enable=1, dig=0 and cnt=0, the shadow registers capture seg0..seg3 and frame_tick=1. frame_tick is 0 in every other cycle. The first latch occurs in the first enabled cycle after reset.
- Input changes outside the latch cycle are not displayed until the next frame.
- enable=0: on that edge cnt and dig are forced to 0, outputs go dark and frame_tick=0. Shadow registers are held.
- When enable returns to 1, the following cycle is a latch cycle, so a full fresh frame starts.
- Reset mid-frame: next cycle takes the reset values exactly, with no partial digit shown. Latching resumes at the first enabled cycle after reset.
- Never drive two anodes low at once, including at slot boundaries and on enable or reset transitions.

Decomposition:
- Shared package sevenseg_pkg holds:
  - SEG_ALL_OFF=7'h7F and AN_ALL_OFF=4'hF;
  - digit-index width 2;
  - the segment bit-order constants (SEG_A=0 ... SEG_G=6), shared with the FSM's pattern encoder.
- One natural sub-module: sevenseg_slot_timer.
  - Parameters: REFRESH_DIV, BLANK_CYCLES.
  - Owns cnt and dig.
  - Emits in_show, dig and frame_start.
- The top level holds the shadow registers and the output flip-flops.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW_IN=1; seg0=7'h40, seg1=7'h79, seg2=7'h24, seg3=7'h30; enable=1):
- Reset held for 2 cycles -> an_n=4'hF, seg_n=7'h7F, frame_tick=0 throughout the reset cycles.
- Release reset -> frame_tick=1 for exactly cycle 0. Cycles 0-1: an_n=4'hF. Cycles 2-7: an_n=4'b1110 and seg_n=7'h40. Cycles 10-15: an_n=4'b1101, seg_n=7'h79. Cycles 18-23: an_n=4'b1011, seg_n=7'h24. Cycles 26-31: an_n=4'b0111, seg_n=7'h30. Cycle 32: frame_tick=1 again.
- Change seg2 to 7'h00 at cycle 20 -> cycles 20-23 still show 7'h24. The latch at cycle 32 takes the new value. Cycles 50-55 show an_n=4'b1011, seg_n=7'h00.
- Drop enable at cycle 12 for 5 cycles -> outputs dark on the next edge and held dark. The first cycle after re-enable is a latch cycle (frame_tick=1, dig=0), and digit 0 shows after a further 2 blank cycles.
- Assert reset at cycle 27 (mid digit 3) -> next cycle an_n=4'hF, seg_n=7'h7F. The post-reset sequence is identical to scenario 2.
- Run with SEG_ACTIVE_LOW_IN=0 and seg0=7'h3F -> during digit-0 SHOW, seg_n=7'h40. On every cycle across all scenarios, no more than one an_n bit is 0.
